truth_table_probe: RTL

Sequential characterizer for a 3-input combinational logic gate. It drives all eight input combinations onto a device under test and samples the gate's output for each one. It then assembles the 8-bit truth-table code, in the same hex naming used for the gate library (e.g. 0x8A), and compares it against an expected code. It sits in the bench/bring-up path next to the gate library and reads back the function that a gate module implements.

---
 rtl/truth_table_probe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/truth_table_probe.sv
// truth_table_probe: walks a 3-input gate through all eight input rows,
// samples its output and assembles the 8-bit truth-table code.
module truth_table_probe #(
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_COUNT  = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       drive_in1,
    output logic       drive_in2,
    output logic       drive_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       code_valid,
    output logic [7:0] unstable_mask,
    output logic       match
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int CMAX = (SETTLE_CYCLES > SAMPLE_COUNT) ?
                          SETTLE_CYCLES : SAMPLE_COUNT;
    localparam int CW = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_COUNT - 1);

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             row_q, row_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [7:0]             exp_q, exp_d;
    logic [7:0]             shadow_q, shadow_d;
    logic [7:0]             smask_q, smask_d;
    logic                   prev_q, prev_d;
    logic [7:0]             code_q, code_d;
    logic [7:0]             mask_q, mask_d;
    logic                   valid_q, valid_d;
    logic                   match_q, match_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   sync_shift;
    logic                   smp;
    logic [2:0]             bit_idx;

    assign sync_shift = {sync_q, dut_out};
    assign smp        = sync_q[SYNC_STAGES-1];
    // Row k lands in code bit 7-k, so row 000 is the MSB.
    assign bit_idx    = ~row_q;

    // Shift the asynchronous gate output through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_shift[SYNC_STAGES-1:0];
        end
    end

    // Sequencer next-state: row stepping, sampling and result assembly.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        exp_d    = exp_q;
        shadow_d = shadow_q;
        smask_d  = smask_q;
        prev_d   = prev_q;
        code_d   = code_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        match_d  = match_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_SETTLE;
                    busy_d   = 1'b1;
                    row_d    = 3'd0;
                    cnt_d    = '0;
                    exp_d    = expected;
                    valid_d  = 1'b0;
                    match_d  = 1'b0;
                    mask_d   = 8'h00;
                    shadow_d = 8'h00;
                    smask_d  = 8'h00;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end else if (cnt_q == SET_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    row_d   = 3'd0;
                    cnt_d   = '0;
                end else begin
                    prev_d            = smp;
                    shadow_d[bit_idx] = smp;
                    if (cnt_q != '0 && smp != prev_q) begin
                        smask_d[bit_idx] = 1'b1;
                    end
                    if (cnt_q == SMP_LAST) begin
                        cnt_d = '0;
                        if (row_q == 3'd7) begin
                            state_d = S_FINISH;
                            code_d  = shadow_d;
                            mask_d  = smask_d;
                            valid_d = 1'b1;
                            match_d = (shadow_d == exp_q) &&
                                      (smask_d == 8'h00);
                            done_d  = 1'b1;
                        end else begin
                            row_d   = row_q + 3'd1;
                            state_d = S_SETTLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                row_d   = 3'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // Register sequencer state and published results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            row_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exp_q    <= 8'h00;
            shadow_q <= 8'h00;
            smask_q  <= 8'h00;
            prev_q   <= 1'b0;
            code_q   <= 8'h00;
            mask_q   <= 8'h00;
            valid_q  <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            smask_q  <= smask_d;
            prev_q   <= prev_d;
            code_q   <= code_d;
            mask_q   <= mask_d;
            valid_q  <= valid_d;
            match_q  <= match_d;
        end
    end

    assign drive_in1     = row_q[2];
    assign drive_in2     = row_q[1];
    assign drive_in3     = row_q[0];
    assign busy          = busy_q;
    assign done          = done_q;
    assign code          = code_q;
    assign code_valid    = valid_q;
    assign unstable_mask = mask_q;
    assign match         = match_q;

endmodule
